// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write tracker with decode stall generation.
// Optional AR-register tracking is enabled by defining SCOREBOARD_AR_EN.
`ifndef HBIT_SRC_GP
`define HBIT_SRC_GP 3
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef HBIT_SRC_AR
`define HBIT_SRC_AR 1
`endif
`ifndef HBIT_TGT_AR
`define HBIT_TGT_AR 1
`endif

module reg_scoreboard_cell #(
   parameter int CNT_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             inc_i,
   input  logic             inc_late_i,
   input  logic             dec_i,
   input  logic             late_dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [CNT_W-1:0] late_o,
   output logic             err_o
);
   localparam logic [CNT_W-1:0] MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d, late_q, late_d;
   logic             cnt_err, late_err;

   // Same-cycle inc/dec cancel; an illegal step holds the counter and flags.
   always_comb begin
      cnt_d    = cnt_q;
      late_d   = late_q;
      cnt_err  = 1'b0;
      late_err = 1'b0;
      if (inc_i & ~dec_i) begin
         if (cnt_q == MAX) cnt_err = 1'b1;
         else              cnt_d   = cnt_q + CNT_W'(1);
      end else if (dec_i & ~inc_i) begin
         if (cnt_q == '0) cnt_err = 1'b1;
         else             cnt_d   = cnt_q - CNT_W'(1);
      end
      if (inc_late_i & ~late_dec_i) begin
         if (late_q == MAX) late_err = 1'b1;
         else               late_d   = late_q + CNT_W'(1);
      end else if (late_dec_i & ~inc_late_i) begin
         if (late_q == '0) late_err = 1'b1;
         else              late_d   = late_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i | flush_i) begin
         cnt_q  <= '0;
         late_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         late_q <= late_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign late_o = late_q;
   assign err_o  = ~flush_i & (cnt_err | late_err);
endmodule

module reg_scoreboard #(
   parameter int GP_REGS = 16,
   parameter int AR_REGS = 4,
   parameter int CNT_W   = 2
) (
   input  logic                  iw_clk,
   input  logic                  iw_rst,
   input  logic                  iw_dec_valid,
   input  logic [`HBIT_SRC_GP:0] iw_src_gp,
   input  logic [`HBIT_TGT_GP:0] iw_tgt_gp,
   input  logic                  iw_issue_valid,
   input  logic                  iw_issue_gp_we,
   input  logic                  iw_issue_late,
   input  logic                  iw_late_done_valid,
   input  logic [`HBIT_TGT_GP:0] iw_late_done_gp,
   input  logic                  iw_retire_valid,
   input  logic [`HBIT_TGT_GP:0] iw_retire_gp,
   input  logic                  iw_flush,
`ifdef SCOREBOARD_AR_EN
   input  logic [`HBIT_SRC_AR:0] iw_src_ar,
   input  logic [`HBIT_TGT_AR:0] iw_tgt_ar,
   input  logic                  iw_issue_ar_we,
   input  logic                  iw_issue_ar_late,
   input  logic                  iw_late_done_ar_valid,
   input  logic [`HBIT_TGT_AR:0] iw_late_done_ar,
   input  logic                  iw_retire_ar_valid,
   input  logic [`HBIT_TGT_AR:0] iw_retire_ar,
   output logic [AR_REGS-1:0]    or_pending_ar,
   output logic [AR_REGS-1:0]    or_late_ar,
`endif
   output logic                  or_stall,
   output logic [GP_REGS-1:0]    or_pending_gp,
   output logic [GP_REGS-1:0]    or_late_gp,
   output logic                  or_err
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [GP_REGS-1:0][CNT_W-1:0] gp_cnt, gp_late;
   logic [GP_REGS-1:0]            gp_err;
   logic                          stall_gp, stall_ar, issue_acc, err_any;
   logic                          or_err_q, or_err_d;

   // The target is also read as an operand, so a late target stalls too.
   assign stall_gp = (gp_late[iw_src_gp] != '0) | (gp_late[iw_tgt_gp] != '0) |
                     (iw_issue_gp_we & (gp_cnt[iw_tgt_gp] == CNT_MAX));
   assign or_stall  = iw_dec_valid & (stall_gp | stall_ar);
   assign issue_acc = iw_issue_valid & ~or_stall;

   for (genvar g = 0; g < GP_REGS; g++) begin : g_gp
      reg_scoreboard_cell #(.CNT_W(CNT_W)) u_cell (
         .clk_i      (iw_clk),
         .rst_i      (iw_rst),
         .flush_i    (iw_flush),
         .inc_i      (issue_acc & iw_issue_gp_we & (iw_tgt_gp == (`HBIT_TGT_GP+1)'(g))),
         .inc_late_i (issue_acc & iw_issue_gp_we & iw_issue_late &
                      (iw_tgt_gp == (`HBIT_TGT_GP+1)'(g))),
         .dec_i      (iw_retire_valid & (iw_retire_gp == (`HBIT_TGT_GP+1)'(g))),
         .late_dec_i (iw_late_done_valid & (iw_late_done_gp == (`HBIT_TGT_GP+1)'(g))),
         .cnt_o      (gp_cnt[g]),
         .late_o     (gp_late[g]),
         .err_o      (gp_err[g])
      );
      assign or_pending_gp[g] = |gp_cnt[g];
      assign or_late_gp[g]    = |gp_late[g];
   end

`ifdef SCOREBOARD_AR_EN
   logic [AR_REGS-1:0][CNT_W-1:0] ar_cnt, ar_late;
   logic [AR_REGS-1:0]            ar_err;

   assign stall_ar = (ar_late[iw_src_ar] != '0) | (ar_late[iw_tgt_ar] != '0) |
                     (iw_issue_ar_we & (ar_cnt[iw_tgt_ar] == CNT_MAX));

   for (genvar a = 0; a < AR_REGS; a++) begin : g_ar
      reg_scoreboard_cell #(.CNT_W(CNT_W)) u_cell (
         .clk_i      (iw_clk),
         .rst_i      (iw_rst),
         .flush_i    (iw_flush),
         .inc_i      (issue_acc & iw_issue_ar_we & (iw_tgt_ar == (`HBIT_TGT_AR+1)'(a))),
         .inc_late_i (issue_acc & iw_issue_ar_we & iw_issue_ar_late &
                      (iw_tgt_ar == (`HBIT_TGT_AR+1)'(a))),
         .dec_i      (iw_retire_ar_valid & (iw_retire_ar == (`HBIT_TGT_AR+1)'(a))),
         .late_dec_i (iw_late_done_ar_valid & (iw_late_done_ar == (`HBIT_TGT_AR+1)'(a))),
         .cnt_o      (ar_cnt[a]),
         .late_o     (ar_late[a]),
         .err_o      (ar_err[a])
      );
      assign or_pending_ar[a] = |ar_cnt[a];
      assign or_late_ar[a]    = |ar_late[a];
   end

   assign err_any = (|gp_err) | (|ar_err);
`else
   assign stall_ar = 1'b0;
   assign err_any  = |gp_err;
`endif

   // An issue offered under stall is a protocol error unless flushed away.
   assign or_err_d = or_err_q | err_any | (~iw_flush & iw_issue_valid & or_stall);

   always_ff @(posedge iw_clk) begin
      if (iw_rst) or_err_q <= 1'b0;
      else        or_err_q <= or_err_d;
   end

   assign or_err = or_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed load-use/overflow/flush steps plus
// randomized traffic compared against an arithmetic per-register reference model.
`ifndef HBIT_SRC_GP
`define HBIT_SRC_GP 3
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif

module tb_reg_scoreboard;
   localparam int GP   = 16;
   localparam int CW   = 2;
   localparam int MAXC = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst, dv, iv, we, lt, ldv, rv, fl;
   logic [`HBIT_SRC_GP:0] src;
   logic [`HBIT_TGT_GP:0] tgt, ldg, rg;
   logic                  or_stall, or_err;
   logic [GP-1:0]         or_pending_gp, or_late_gp;
`ifdef SCOREBOARD_AR_EN
   logic [3:0]            pend_ar, late_ar;
`endif

   reg_scoreboard #(.GP_REGS(GP), .AR_REGS(4), .CNT_W(CW)) dut (
      .iw_clk(clk), .iw_rst(rst), .iw_dec_valid(dv), .iw_src_gp(src), .iw_tgt_gp(tgt),
      .iw_issue_valid(iv), .iw_issue_gp_we(we), .iw_issue_late(lt),
      .iw_late_done_valid(ldv), .iw_late_done_gp(ldg),
      .iw_retire_valid(rv), .iw_retire_gp(rg), .iw_flush(fl),
`ifdef SCOREBOARD_AR_EN
      .iw_src_ar('0), .iw_tgt_ar('0), .iw_issue_ar_we(1'b0), .iw_issue_ar_late(1'b0),
      .iw_late_done_ar_valid(1'b0), .iw_late_done_ar('0),
      .iw_retire_ar_valid(1'b0), .iw_retire_ar('0),
      .or_pending_ar(pend_ar), .or_late_ar(late_ar),
`endif
      .or_stall(or_stall), .or_pending_gp(or_pending_gp), .or_late_gp(or_late_gp),
      .or_err(or_err)
   );

   int   mcnt[GP], mlate[GP];
   bit   merr;
   int   npass = 0, nfail = 0, ntot = 0;
   logic last_stall;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [GP-1:0] mvec(input bit use_late);
      logic [GP-1:0] v;
      for (int i = 0; i < GP; i++) v[i] = use_late ? (mlate[i] > 0) : (mcnt[i] > 0);
      return v;
   endfunction

   // One cycle: check the combinational stall, advance the model, check registered state.
   task automatic step();
      bit st, acc;
      int dc[GP], dl[GP];
      #2;
      st = dv && (mlate[src] > 0 || mlate[tgt] > 0 || (we && mcnt[tgt] == MAXC));
      last_stall = or_stall;
      check("stall", 32'(or_stall), 32'(st));
      for (int i = 0; i < GP; i++) begin dc[i] = 0; dl[i] = 0; end
      if (rst) begin
         for (int i = 0; i < GP; i++) begin mcnt[i] = 0; mlate[i] = 0; end
         merr = 0;
      end else if (fl) begin
         for (int i = 0; i < GP; i++) begin mcnt[i] = 0; mlate[i] = 0; end
      end else begin
         acc = iv && !st;
         if (iv && st) merr = 1;
         if (acc && we) begin dc[tgt]++; if (lt) dl[tgt]++; end
         if (rv)  dc[rg]--;
         if (ldv) dl[ldg]--;
         for (int i = 0; i < GP; i++) begin
            if (mcnt[i] + dc[i] < 0 || mcnt[i] + dc[i] > MAXC) merr = 1;
            else mcnt[i] += dc[i];
            if (mlate[i] + dl[i] < 0 || mlate[i] + dl[i] > MAXC) merr = 1;
            else mlate[i] += dl[i];
         end
      end
      @(posedge clk);
      #1;
      check("pending_gp", 32'(or_pending_gp), 32'(mvec(0)));
      check("late_gp", 32'(or_late_gp), 32'(mvec(1)));
      check("err", 32'(or_err), 32'(merr));
   endtask

   task automatic drv(input bit dv_, input int src_, input int tgt_, input bit iv_,
                      input bit we_, input bit lt_, input bit ldv_, input int ldg_,
                      input bit rv_, input int rg_, input bit fl_);
      dv = dv_; src = 4'(src_); tgt = 4'(tgt_); iv = iv_; we = we_; lt = lt_;
      ldv = ldv_; ldg = 4'(ldg_); rv = rv_; rg = 4'(rg_); fl = fl_;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; dv = 0; iv = 0; we = 0; lt = 0; ldv = 0; rv = 0; fl = 0;
      src = '0; tgt = '0; ldg = '0; rg = '0;
      for (int i = 0; i < GP; i++) begin mcnt[i] = 0; mlate[i] = 0; end
      merr = 0;
      @(posedge clk); #1;
      do_reset();
      check("rst_pending", 32'(or_pending_gp), 32'h0);
      check("rst_err", 32'(or_err), 32'h0);
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_stall", 32'(last_stall), 32'h0);

      // load-use on r5
      drv(1, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0);
      drv(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("lu_stall", 32'(last_stall), 32'h1);
      drv(1, 5, 0, 0, 0, 0, 1, 5, 0, 0, 0);
      check("lu_stall_done_cycle", 32'(last_stall), 32'h1);
      drv(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("lu_release", 32'(last_stall), 32'h0);
      check("lu_late5", 32'(or_late_gp[5]), 32'h0);
      check("lu_pend5", 32'(or_pending_gp[5]), 32'h1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
      check("lu_retired", 32'(or_pending_gp[5]), 32'h0);

      // alu-use on r3
      drv(1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0);
      drv(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("alu_nostall", 32'(last_stall), 32'h0);
      check("alu_pend3", 32'(or_pending_gp[3]), 32'h1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);

      // overflow on r7
      repeat (3) drv(1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
      drv(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0);
      check("ovf_stall", 32'(last_stall), 32'h1);
      drv(1, 0, 7, 0, 1, 0, 0, 0, 1, 7, 0);
      drv(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0);
      check("ovf_release", 32'(last_stall), 32'h0);
      repeat (2) drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

      // same-cycle issue + retire on r2
      drv(1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0);
      drv(1, 0, 2, 1, 1, 0, 0, 0, 1, 2, 0);
      check("net_pend2", 32'(or_pending_gp[2]), 32'h1);
      check("net_err", 32'(or_err), 32'h0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);

      // underflow on r9
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
      check("udf_err", 32'(or_err), 32'h1);
      check("udf_pend9", 32'(or_pending_gp[9]), 32'h0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("udf_sticky", 32'(or_err), 32'h1);

      // flush with r1 cnt=2 late=1 and a concurrent issue of r4
      drv(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      drv(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      drv(1, 0, 4, 1, 1, 0, 0, 0, 0, 0, 1);
      check("fl_pend", 32'(or_pending_gp), 32'h0);
      check("fl_late", 32'(or_late_gp), 32'h0);
      check("fl_err_kept", 32'(or_err), 32'h1);
      do_reset();
      check("rst_clears_err", 32'(or_err), 32'h0);

      // randomized traffic on a few registers to force collisions
      for (int blk = 0; blk < 4; blk++) begin
         for (int c = 0; c < 100; c++) begin
            bit d;
            d = ($urandom % 4) != 0;
            drv(d, $urandom_range(0, 3), $urandom_range(0, 3), d & $urandom_range(0, 1),
                ($urandom % 4) != 0, ($urandom % 3) == 0,
                ($urandom % 4) == 0, $urandom_range(0, 3),
                ($urandom % 3) == 0, $urandom_range(0, 3), ($urandom % 50) == 0);
         end
         do_reset();
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
